// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: memory-mapped 4-digit 7-segment scan controller with dead-time blanking and PWM brightness
// Ports: clk/rst_n clock and async active-low reset; addr/data_in/we CPU write bus (0x03..0x08);
// data_out combinational readback; seg/dp/an active-low display drives; frame_strobe end-of-frame pulse.
module display_scan_ctrl #(
  parameter int SUB_DIV   = 3125,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  addr,
  input  logic [15:0] data_in,
  input  logic        we,
  output logic [15:0] data_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_strobe
);
  localparam int CW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [CW-1:0] SUB_LAST   = CW'(SUB_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  typedef enum logic [1:0] {OFF, BLANK, ON} state_t;
  state_t           state;
  logic [3:0][6:0]  digit;
  logic [3:0]       dp_mask;
  logic             en;
  logic [2:0]       bright;
  logic [CW-1:0]    sub_cnt;
  logic [2:0]       sub_idx;
  logic [1:0]       dig_idx;
  logic [6:0]       sh_seg;
  logic             sh_dp;
  logic [2:0]       sh_bright;
  logic             unused_bits;
  // digit registers sit at 0x03..0x06, so addr[1:0]+1 maps them onto 0..3
  logic [1:0] ri;
  logic       is_digit;
  logic       sub_wrap;
  logic       slot_end;
  logic       load;
  logic [1:0] nxt;
  logic       lit;
  assign unused_bits = ^data_in[15:7];
  assign ri       = addr[1:0] + 2'd1;
  assign is_digit = addr >= 8'h03 && addr <= 8'h06;
  assign data_out = is_digit ? {9'd0, digit[ri]} :
                    addr == 8'h07 ? {12'd0, dp_mask} :
                    addr == 8'h08 ? {12'd0, bright, en} : 16'd0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit   <= {4{7'h40}};
      dp_mask <= 4'd0;
      en      <= 1'b1;
      bright  <= 3'd7;
    end else if (we) begin
      if (is_digit) digit[ri] <= data_in[6:0];
      if (addr == 8'h07) dp_mask <= data_in[3:0];
      if (addr == 8'h08) {bright, en} <= data_in[3:0];
    end
  end
  assign sub_wrap = sub_cnt == SUB_LAST;
  assign slot_end = state == ON && sub_idx == 3'd7 && sub_wrap;
  // shadows are captured only as a slot starts, so CPU writes never tear a slot
  assign load = en && (slot_end || (state != BLANK && state != ON));
  assign nxt  = slot_end ? dig_idx + 2'd1 : 2'd0;
  // en is checked here too so clearing enable blanks on the very next output cycle
  assign lit  = en && state == ON && sub_idx <= sh_bright;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= OFF;
      sub_cnt      <= '0;
      sub_idx      <= 3'd0;
      dig_idx      <= 2'd0;
      sh_seg       <= 7'h7F;
      sh_dp        <= 1'b0;
      sh_bright    <= 3'd0;
      an           <= 4'hF;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      frame_strobe <= 1'b0;
    end else begin
      an           <= lit ? ~(4'b0001 << dig_idx) : 4'hF;
      seg          <= lit ? sh_seg : 7'h7F;
      dp           <= lit ? ~sh_dp : 1'b1;
      frame_strobe <= en && slot_end && dig_idx == 2'd3;
      if (load) begin
        sh_seg    <= digit[nxt];
        sh_dp     <= dp_mask[nxt];
        sh_bright <= bright;
      end
      if (!en || (state != BLANK && state != ON)) begin
        state   <= en ? BLANK : OFF;
        sub_cnt <= '0;
        sub_idx <= 3'd0;
        dig_idx <= 2'd0;
      end else begin
        sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
        sub_idx <= sub_wrap ? sub_idx + 3'd1 : sub_idx;
        if (state == BLANK && sub_cnt == BLANK_LAST) state <= ON;
        if (slot_end) begin
          state   <= BLANK;
          dig_idx <= dig_idx + 2'd1;
        end
      end
    end
  end
endmodule
